hdlverifier_trigger_sequencer: RTL and testbench

//  Generates the trigger for the data-capture stage from the design-under-test (DUT) signal.

---
 rtl/hdlverifier_trigger_sequencer.sv | 177 +++++++++++++++++
 tb/tb_hdlverifier_trigger_sequencer.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hdlverifier_trigger_sequencer.sv
// Multi-stage masked-compare trigger sequencer feeding the capture buffer.
// Stages are evaluated in order on clk_enable cycles; the final stage fires a trigger pulse.
module hdlverifier_trigger_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_STAGES = 3,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             clk_enable,
  input  logic                             run,
  input  logic [DATA_WIDTH-1:0]            data_in,
  input  logic [NUM_STAGES*DATA_WIDTH-1:0] cfg_value,
  input  logic [NUM_STAGES*DATA_WIDTH-1:0] cfg_mask,
  input  logic [NUM_STAGES*2-1:0]          cfg_mode,
  input  logic [NUM_STAGES*CNT_WIDTH-1:0]  cfg_count,
  input  logic [1:0]                       cfg_last,
  input  logic                             cfg_rearm,
  output logic                             trigger,
  output logic                             armed,
  output logic [1:0]                       stage,
  output logic [CNT_WIDTH-1:0]             fired_count
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARMED = 2'd1;
  localparam logic [1:0] S_FIRED = 2'd2;

  logic [1:0]                       state_q, state_d;
  logic                             run_q;
  logic [NUM_STAGES*DATA_WIDTH-1:0] value_q, mask_q;
  logic [NUM_STAGES*2-1:0]          mode_q;
  logic [NUM_STAGES*CNT_WIDTH-1:0]  count_q;
  logic [1:0]                       last_q;
  logic                             rearm_q;
  logic [1:0]                       stage_q, stage_d;
  logic [CNT_WIDTH-1:0]             occ_q, occ_d;
  logic                             prev_q, prev_d;
  logic                             first_q, first_d;
  logic                             trig_q, trig_d;
  logic [CNT_WIDTH-1:0]             fcnt_q, fcnt_d;

  logic                  run_rise;
  logic [DATA_WIDTH-1:0] sel_val, sel_mask;
  logic [1:0]            sel_mode;
  logic [CNT_WIDTH-1:0]  sel_cnt, cnt_eff;
  logic [CNT_WIDTH:0]    occ_inc;
  logic [1:0]            last_eff;
  logic                  match, evt, done;

  assign run_rise = run & ~run_q;

  always_comb begin
    sel_val  = '0;
    sel_mask = '0;
    sel_mode = '0;
    sel_cnt  = '0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      if (stage_q == 2'(k)) begin
        sel_val  = value_q[k*DATA_WIDTH +: DATA_WIDTH];
        sel_mask = mask_q[k*DATA_WIDTH +: DATA_WIDTH];
        sel_mode = mode_q[k*2 +: 2];
        sel_cnt  = count_q[k*CNT_WIDTH +: CNT_WIDTH];
      end
    end
  end

  always_comb begin
    match   = ((data_in ^ sel_val) & sel_mask) == '0;
    cnt_eff = (sel_cnt == '0) ? CNT_WIDTH'(1) : sel_cnt;
    occ_inc = {1'b0, occ_q} + (CNT_WIDTH+1)'(1);
    done    = occ_inc >= {1'b0, cnt_eff};
    if ({30'd0, last_q} >= NUM_STAGES) last_eff = 2'(NUM_STAGES - 1);
    else                               last_eff = last_q;
    unique case (sel_mode)
      2'b00:   evt = match;
      2'b01:   evt = match & ~prev_q & ~first_q;
      2'b10:   evt = ~match & prev_q & ~first_q;
      default: evt = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    occ_d   = occ_q;
    prev_d  = prev_q;
    first_d = first_q;
    trig_d  = trig_q;
    fcnt_d  = fcnt_q;
    // a low run wins over anything else, including a fire this cycle
    if (!run) begin
      state_d = S_IDLE;
      stage_d = '0;
      occ_d   = '0;
      prev_d  = 1'b0;
      first_d = 1'b1;
      trig_d  = 1'b0;
    end else if (run_rise) begin
      state_d = S_ARMED;
      stage_d = '0;
      occ_d   = '0;
      prev_d  = 1'b0;
      first_d = 1'b1;
      trig_d  = 1'b0;
      fcnt_d  = '0;
    end else begin
      if (trig_q && clk_enable) trig_d = 1'b0;
      if (state_q == S_ARMED && clk_enable) begin
        prev_d  = match;
        first_d = 1'b0;
        if (evt) begin
          if (!done) begin
            occ_d = occ_inc[CNT_WIDTH-1:0];
          end else if (stage_q < last_eff) begin
            stage_d = stage_q + 2'd1;
            occ_d   = '0;
            first_d = 1'b1;
          end else begin
            trig_d  = 1'b1;
            occ_d   = '0;
            stage_d = '0;
            first_d = (stage_q != 2'd0);
            if (fcnt_q != '1) fcnt_d = fcnt_q + 1'b1;
            if (!rearm_q) state_d = S_FIRED;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      run_q   <= 1'b0;
      stage_q <= '0;
      occ_q   <= '0;
      prev_q  <= 1'b0;
      first_q <= 1'b0;
      trig_q  <= 1'b0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= run;
      stage_q <= stage_d;
      occ_q   <= occ_d;
      prev_q  <= prev_d;
      first_q <= first_d;
      trig_q  <= trig_d;
      fcnt_q  <= fcnt_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      value_q <= '0;
      mask_q  <= '0;
      mode_q  <= '0;
      count_q <= '0;
      last_q  <= '0;
      rearm_q <= 1'b0;
    end else if (run_rise) begin
      value_q <= cfg_value;
      mask_q  <= cfg_mask;
      mode_q  <= cfg_mode;
      count_q <= cfg_count;
      last_q  <= cfg_last;
      rearm_q <= cfg_rearm;
    end
  end

  assign trigger     = trig_q;
  assign armed       = (state_q == S_ARMED);
  assign stage       = stage_q;
  assign fired_count = fcnt_q;

endmodule

// File: tb/tb_hdlverifier_trigger_sequencer.sv
// Bench for the trigger sequencer: directed scenarios plus random
// stimulus, all checked against a behavioural model.
module tb_hdlverifier_trigger_sequencer;

  localparam int DW = 8;
  localparam int NS = 3;
  localparam int CW = 8;

  logic           clk = 1'b0;
  logic           reset_n;
  logic           clk_enable;
  logic           run;
  logic [DW-1:0]  data_in;
  logic [NS*DW-1:0] cfg_value, cfg_mask;
  logic [NS*2-1:0]  cfg_mode;
  logic [NS*CW-1:0] cfg_count;
  logic [1:0]     cfg_last;
  logic           cfg_rearm;
  logic           trigger, armed;
  logic [1:0]     stage;
  logic [CW-1:0]  fired_count;

  hdlverifier_trigger_sequencer #(
    .DATA_WIDTH(DW), .NUM_STAGES(NS), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .clk_enable(clk_enable),
    .run(run), .data_in(data_in), .cfg_value(cfg_value),
    .cfg_mask(cfg_mask), .cfg_mode(cfg_mode),
    .cfg_count(cfg_count), .cfg_last(cfg_last),
    .cfg_rearm(cfg_rearm), .trigger(trigger), .armed(armed),
    .stage(stage), .fired_count(fired_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // behavioural model state
  int sv[NS], sm[NS], smo[NS], sc[NS];
  int slast, srearm;
  bit rp, m_arm, m_prev, m_fresh, m_trig;
  int m_stage, m_occ, m_fc;

  task automatic model_reset();
    for (int k = 0; k < NS; k++) begin
      sv[k] = 0; sm[k] = 0; smo[k] = 0; sc[k] = 0;
    end
    slast = 0; srearm = 0; rp = 0; m_arm = 0; m_prev = 0;
    m_fresh = 0; m_trig = 0; m_stage = 0; m_occ = 0; m_fc = 0;
  endtask

  task automatic model_step();
    int lst, need;
    bit hit, ev;
    if (!run) begin
      m_arm = 0; m_stage = 0; m_occ = 0; m_trig = 0;
    end else if (!rp) begin
      for (int k = 0; k < NS; k++) begin
        sv[k]  = int'(cfg_value[k*DW +: DW]);
        sm[k]  = int'(cfg_mask[k*DW +: DW]);
        smo[k] = int'(cfg_mode[k*2 +: 2]);
        sc[k]  = int'(cfg_count[k*CW +: CW]);
      end
      slast = int'(cfg_last); srearm = int'(cfg_rearm);
      m_arm = 1; m_stage = 0; m_occ = 0; m_fc = 0;
      m_trig = 0; m_fresh = 1;
    end else begin
      if (clk_enable && m_trig) m_trig = 0;
      if (m_arm && clk_enable) begin
        hit = ((int'(data_in) ^ sv[m_stage]) & sm[m_stage]) == 0;
        case (smo[m_stage])
          0: ev = hit;
          1: ev = hit && !m_prev && !m_fresh;
          2: ev = !hit && m_prev && !m_fresh;
          default: ev = 1;
        endcase
        m_prev = hit; m_fresh = 0;
        lst  = (slast >= NS) ? NS - 1 : slast;
        need = (sc[m_stage] == 0) ? 1 : sc[m_stage];
        if (ev) begin
          if (m_occ + 1 < need) begin
            m_occ++;
          end else if (m_stage < lst) begin
            m_stage++; m_occ = 0; m_fresh = 1;
          end else begin
            m_trig = 1; m_occ = 0;
            if (m_fc < 255) m_fc++;
            if (m_stage != 0) m_fresh = 1;
            m_stage = 0;
            if (srearm == 0) m_arm = 0;
          end
        end
      end
    end
    rp = run;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check("trigger", 32'(trigger), 32'(m_trig));
    check("armed", 32'(armed), 32'(m_arm));
    check("stage", 32'(stage), 32'(m_stage));
    check("fired_count", 32'(fired_count), 32'(m_fc));
  endtask

  task automatic set_stage(input int k, input int v, input int mk,
                           input int md, input int cn);
    cfg_value[k*DW +: DW] = DW'(v);
    cfg_mask[k*DW +: DW]  = DW'(mk);
    cfg_mode[k*2 +: 2]    = 2'(md);
    cfg_count[k*CW +: CW] = CW'(cn);
  endtask

  task automatic arm();
    run = 1'b0; cyc();
    run = 1'b1; cyc();
  endtask

  task automatic async_reset();
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_trigger", 32'(trigger), 0);
    check("rst_armed", 32'(armed), 0);
    check("rst_stage", 32'(stage), 0);
    check("rst_fired_count", 32'(fired_count), 0);
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic rand_cfg();
    for (int k = 0; k < NS; k++) begin
      int mk;
      case ($urandom_range(0, 3))
        0: mk = 8'hFF;
        1: mk = 8'h0F;
        2: mk = 0;
        default: mk = int'($urandom_range(0, 255));
      endcase
      set_stage(k, int'($urandom_range(0, 255)), mk,
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end
    cfg_last  = 2'($urandom_range(0, 3));
    cfg_rearm = 1'($urandom_range(0, 1));
  endtask

  task automatic rand_data();
    int k;
    case ($urandom_range(0, 3))
      0: data_in = DW'($urandom_range(0, 255));
      1: ;
      default: begin
        k = int'($urandom_range(0, NS - 1));
        data_in = DW'((sv[k] & sm[k]) |
                      (int'($urandom_range(0, 255)) & ~sm[k]));
      end
    endcase
  endtask

  int pulses;

  initial begin
    reset_n = 1'b0; clk_enable = 1'b0; run = 1'b0; data_in = '0;
    cfg_value = '0; cfg_mask = '0; cfg_mode = '0; cfg_count = '0;
    cfg_last = '0; cfg_rearm = 1'b0;
    model_reset();
    #1;
    check("reset_trigger", 32'(trigger), 0);
    check("reset_armed", 32'(armed), 0);
    check("reset_stage", 32'(stage), 0);
    check("reset_fired_count", 32'(fired_count), 0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // single level stage, no rearm
    set_stage(0, 8'h5A, 8'hFF, 0, 1);
    cfg_last = 2'd0; cfg_rearm = 1'b0;
    arm();
    clk_enable = 1'b1; data_in = 8'h00; cyc();
    data_in = 8'h5A; cyc();
    check("t1_trig_high", 32'(trigger), 1);
    data_in = 8'h00; cyc();
    check("t1_trig_low", 32'(trigger), 0);
    check("t1_armed", 32'(armed), 0);
    check("t1_count", 32'(fired_count), 1);

    // two-stage sequence: level x3 then rise
    set_stage(0, 8'h11, 8'hFF, 0, 3);
    set_stage(1, 8'h22, 8'hFF, 1, 1);
    cfg_last = 2'd1;
    arm();
    data_in = 8'h11; cyc(); cyc(); cyc();
    check("t2_stage1", 32'(stage), 1);
    data_in = 8'h00; cyc();
    data_in = 8'h22; cyc();
    check("t2_trig", 32'(trigger), 1);
    check("t2_stage0", 32'(stage), 0);

    // enable gating: trigger held across disabled cycles
    set_stage(0, 8'h5A, 8'hFF, 0, 1);
    cfg_last = 2'd0;
    arm();
    clk_enable = 1'b0; data_in = 8'h5A; cyc();
    check("t3_gated", 32'(trigger), 0);
    clk_enable = 1'b1; cyc();
    clk_enable = 1'b0; data_in = 8'h00; cyc(); cyc();
    check("t3_held", 32'(trigger), 1);
    clk_enable = 1'b1; cyc();
    check("t3_cleared", 32'(trigger), 0);

    // rearm with count 2
    set_stage(0, 8'hAA, 8'hFF, 0, 2);
    cfg_rearm = 1'b1;
    arm();
    data_in = 8'hAA; pulses = 0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      if (trigger) pulses++;
    end
    check("t4_pulses", 32'(pulses), 4);
    check("t4_count", 32'(fired_count), 4);

    // saturation: always mode, count 1, rearm
    set_stage(0, 0, 0, 3, 1);
    arm();
    for (int i = 0; i < 270; i++) cyc();
    check("t4_saturate", 32'(fired_count), 255);

    // disarm in the same cycle as the final event
    set_stage(0, 8'h5A, 8'hFF, 0, 2);
    arm();
    data_in = 8'h5A; cyc(); cyc(); cyc(); cyc();
    data_in = 8'h00; cyc(); cyc();
    check("t5_pre", 32'(fired_count), 2);
    data_in = 8'h5A; cyc();
    run = 1'b0; cyc();
    check("t5_trig", 32'(trigger), 0);
    check("t5_armed", 32'(armed), 0);
    check("t5_count", 32'(fired_count), 2);

    // rise with data already matching, then shadowed cfg change
    set_stage(0, 8'h33, 8'hFF, 1, 1);
    cfg_rearm = 1'b0;
    data_in = 8'h33;
    arm();
    cyc(); cyc(); cyc();
    check("t6_no_fire", 32'(trigger), 0);
    cfg_value[7:0] = 8'h00;
    data_in = 8'h00; cyc();
    check("t6_shadow", 32'(trigger), 0);
    data_in = 8'h33; cyc();
    check("t6_fire", 32'(trigger), 1);

    // reset mid-stage
    set_stage(0, 8'h11, 8'hFF, 0, 3);
    cfg_last = 2'd1;
    arm();
    data_in = 8'h11; cyc(); cyc(); cyc();
    async_reset();

    // randomized sequences
    for (int it = 0; it < 60; it++) begin
      rand_cfg();
      run = 1'b0; cyc();
      run = 1'b1; cyc();
      for (int c = 0; c < int'($urandom_range(20, 60)); c++) begin
        clk_enable = ($urandom_range(0, 3) != 0);
        rand_data();
        if ($urandom_range(0, 29) == 0) run = 1'b0;
        else if ($urandom_range(0, 9) == 0) run = 1'b1;
        if ($urandom_range(0, 19) == 0) rand_cfg();
        cyc();
      end
      if ($urandom_range(0, 7) == 0) async_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
